// File: rtl/f1_pkg.sv
// f1_pkg: shared types and constants for the F1 start-lights timing blocks
package f1_pkg;
  typedef enum logic [1:0] {IDLE, COUNT, DONE, HOLD} delay_state_t;
  localparam int LFSR_W = 7;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 7'b1000100;
endpackage

// File: rtl/lfsr7.sv
// lfsr7: free-running x^7+x^3+1 Fibonacci LFSR with a zero-safe reset seed
module lfsr7
  import f1_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] q
);
  always_ff @(posedge clk)
    if (rst) q <= (seed == '0) ? LFSR_W'(1) : seed;
    else q <= {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
endmodule

// File: rtl/f1_delay.sv
// f1_delay: pseudo-random delay after the start lights, ending in a one-cycle time_out pulse
module f1_delay
  import f1_pkg::*;
#(
  parameter logic [6:0] SEED = 7'h01,
  parameter int MIN_DELAY = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       trigger,
  output logic       time_out,
  output logic       busy,
  output logic [7:0] delay_val
);
  delay_state_t state, state_n;
  logic [LFSR_W-1:0] lfsr;
  logic [7:0] count, count_n, delay_n, load;
  logic trig_d, start;
  lfsr7 u_lfsr (.clk(clk), .rst(rst), .seed(SEED), .q(lfsr));
  assign start = trigger & ~trig_d;
  assign load = {1'b0, lfsr} + 8'(MIN_DELAY);
  assign time_out = (state == DONE);
  assign busy = (state == COUNT);
  // trig_d resets high so a trigger already asserted at reset release is not an edge
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      count <= '0;
      delay_val <= '0;
      trig_d <= 1'b1;
    end else begin
      state <= state_n;
      count <= count_n;
      delay_val <= delay_n;
      trig_d <= trigger;
    end
  always_comb begin
    state_n = state;
    count_n = count;
    delay_n = delay_val;
    unique case (state)
      IDLE: if (start) begin
        count_n = load;
        delay_n = load;
        state_n = COUNT;
      end
      COUNT: if (en) begin
        if (count == 8'd1) state_n = DONE;
        else count_n = count - 8'd1;
      end
      DONE: state_n = trigger ? HOLD : IDLE;
      HOLD: state_n = trigger ? HOLD : IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule
